// File: rtl/db15_shift_reader.sv
// DB15 UserIO joystick front end: clocks two cascaded PISO shift registers,
// assembles both 12-button player words and publishes them once per frame.
//
// state   | meaning
// S_IDLE  | gap between frames, JOY_LOAD high, JOY_CLK low
// S_LOAD  | parallel-load strobe held low
// S_LOW   | JOY_CLK low half; sample bit k on the last cycle
// S_HIGH  | JOY_CLK high half; advance k or finish the frame
// S_LATCH | one-cycle publish of both player words with frame_done
module db15_shift_reader #(
  parameter int CLK_DIV     = 24,
  parameter int NBITS       = 12,
  parameter int IDLE_CYCLES = 1000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int CMAX = (CLK_DIV > IDLE_CYCLES) ? CLK_DIV : IDLE_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int FB   = 2 * NBITS;
  localparam int KW   = $clog2(FB);

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(FB - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOW, S_HIGH, S_LATCH} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [KW-1:0]   k, k_nx;
  logic            sample;
  logic [FB-1:0]   shreg;
  logic            sync1, sync2;
  logic [NBITS-1:0] p1, p2;

  // Buttons are active-low on the wire; first bit shifted ends up at index 0.
  assign p1 = ~shreg[NBITS-1:0];
  assign p2 = ~shreg[FB-1:NBITS];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - 1'b1;
    k_nx     = k;
    sample   = 1'b0;
    case (state)
      S_IDLE:
        if (cnt == '0) begin
          state_nx = S_LOAD;
          cnt_nx   = DIV_LAST;
        end
      S_LOAD:
        if (cnt == '0) begin
          state_nx = S_LOW;
          cnt_nx   = DIV_LAST;
          k_nx     = '0;
        end
      S_LOW:
        if (cnt == '0) begin
          sample   = 1'b1;
          state_nx = S_HIGH;
          cnt_nx   = DIV_LAST;
        end
      S_HIGH:
        if (cnt == '0) begin
          cnt_nx = DIV_LAST;
          if (k == K_LAST) begin
            state_nx = S_LATCH;
          end else begin
            k_nx     = k + 1'b1;
            state_nx = S_LOW;
          end
        end
      S_LATCH: begin
        state_nx = S_IDLE;
        cnt_nx   = IDLE_LAST;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = IDLE_LAST;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= IDLE_LAST;
      k          <= '0;
      shreg      <= '0;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      JOY_CLK    <= 1'b0;
      JOY_LOAD   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      k          <= k_nx;
      sync1      <= JOY_DATA;
      sync2      <= sync1;
      if (sample) shreg <= {sync2, shreg[FB-1:1]};
      JOY_CLK    <= (state_nx == S_HIGH);
      JOY_LOAD   <= (state_nx != S_LOAD);
      frame_done <= (state_nx == S_LATCH);
      if (state_nx == S_LATCH) begin
        joystick1 <= 16'(p1);
        joystick2 <= 16'(p2);
      end
    end
  end

endmodule

// File: tb/tb_db15_shift_reader.sv
// Bench for db15_shift_reader: behavioural DB15 adapter drives JOY_DATA,
// a frame monitor checks strobe timing and published words.
module tb_db15_shift_reader;

  localparam int FRAME = 2177;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        JOY_DATA;
  logic        JOY_CLK, JOY_LOAD, frame_done;
  logic [15:0] joystick1, joystick2;

  int n_cmp = 0;
  int n_bad = 0;

  db15_shift_reader dut (
    .clk_sys(clk_sys), .reset(reset), .JOY_DATA(JOY_DATA),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD),
    .joystick1(joystick1), .joystick2(joystick2), .frame_done(frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Adapter model: buttons pressed by the "player", captured at load,
  // presented bit by bit on each JOY_CLK rise; noise on the line otherwise.
  logic [11:0]  cur_p1 = '0, cur_p2 = '0;
  logic [23:0]  shift_word = '0;
  logic [31:0]  exp_q[$];
  int           idx = 0;
  bit           active = 0;
  logic         a_prev_load = 1'b1, a_prev_clk = 1'b0;

  initial begin
    JOY_DATA = 1'b1;
    forever begin
      @(posedge clk_sys);
      #1;
      if (reset) begin
        active = 0;
        exp_q.delete();
      end else begin
        if (!JOY_LOAD) begin
          if (a_prev_load) begin
            shift_word = {cur_p2, cur_p1};
            exp_q.push_back({4'h0, cur_p2, 4'h0, cur_p1});
          end
          active = 1;
          idx = 0;
        end else if (JOY_CLK && !a_prev_clk) begin
          idx++;
        end
        if (frame_done) active = 0;
      end
      a_prev_load = JOY_LOAD;
      a_prev_clk  = JOY_CLK;
      if (active) JOY_DATA = (idx < 24) ? ~shift_word[idx] : 1'b1;
      else        JOY_DATA = 1'($urandom_range(0, 1));
    end
  end

  // Frame monitor: strobe shape, frame period, output stability, model words.
  int   mon_cyc = 0, last_fd = 0;
  bit   have_fd = 0;
  int   load_cnt, load_runs, load_bad, rises, hi_len, hi_bad, change_bad;
  logic m_prev_load = 1'b1, m_prev_clk = 1'b0;
  logic [15:0] prev_j1 = '0, prev_j2 = '0;
  logic [31:0] e;

  initial begin
    load_cnt = 0; load_runs = 0; load_bad = 0; rises = 0; hi_len = 0; hi_bad = 0;
    change_bad = 0;
    forever begin
      @(negedge clk_sys);
      mon_cyc++;
      if (reset) begin
        load_cnt = 0; load_runs = 0; load_bad = 0; rises = 0; hi_len = 0; hi_bad = 0;
        have_fd = 0;
      end else begin
        if (!JOY_LOAD) begin
          load_cnt++;
          if (JOY_CLK) load_bad++;
          if (m_prev_load) load_runs++;
        end
        if (JOY_CLK) begin
          hi_len++;
          if (!m_prev_clk) rises++;
        end else if (m_prev_clk) begin
          if (hi_len != 24) hi_bad++;
          hi_len = 0;
        end
        if ((joystick1 !== prev_j1 || joystick2 !== prev_j2) && !frame_done) change_bad++;
        if (frame_done) begin
          check("load_low_cycles", load_cnt, 24);
          check("load_runs", load_runs, 1);
          check("clk_high_during_load", load_bad, 0);
          check("clk_rises", rises, 24);
          check("clk_high_len_errors", hi_bad, 0);
          check("outputs_changed_outside_latch", change_bad, 0);
          if (have_fd) check("frame_period", mon_cyc - last_fd, FRAME);
          if (exp_q.size() == 0) begin
            check("model_queue_empty_at_frame_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("model_joystick1", {16'h0, joystick1}, {16'h0, e[15:0]});
            check("model_joystick2", {16'h0, joystick2}, {16'h0, e[31:16]});
          end
          have_fd = 1; last_fd = mon_cyc;
          load_cnt = 0; load_runs = 0; load_bad = 0; rises = 0; hi_bad = 0;
        end
      end
      m_prev_load = JOY_LOAD;
      m_prev_clk  = JOY_CLK;
      prev_j1 = joystick1;
      prev_j2 = joystick2;
    end
  end

  // Cycles counted from the reset-release cycle (cycle 1) to the frame_done cycle.
  task automatic wait_fd(output int cyc, output bit ok);
    cyc = 1;
    ok  = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_sys);
      cyc++;
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("frame_done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [11:0] p1, p2;
    logic [15:0] e1, e2;
  } vec_t;

  vec_t vecs[6];
  int   cyc, r;
  bit   ok;
  logic pc;

  initial begin
    vecs[0] = '{12'h000, 12'h000, 16'h0000, 16'h0000};
    vecs[1] = '{12'h001, 12'h010, 16'h0001, 16'h0010};
    vecs[2] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000};
    vecs[3] = '{12'h000, 12'hFFF, 16'h0000, 16'h0FFF};
    vecs[4] = '{12'hA5A, 12'h3C3, 16'h0A5A, 16'h03C3};
    vecs[5] = '{12'h800, 12'h001, 16'h0800, 16'h0001};

    // Reset held 5 cycles.
    reset = 1'b1;
    repeat (5) @(negedge clk_sys);
    check("rst_joy_clk", JOY_CLK, 0);
    check("rst_joy_load", JOY_LOAD, 1);
    check("rst_joystick1", joystick1, 0);
    check("rst_joystick2", joystick2, 0);
    check("rst_frame_done", frame_done, 0);

    cur_p1 = vecs[0].p1; cur_p2 = vecs[0].p2;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wait_fd(cyc, ok);
      if (i == 0) check("first_frame_done_cycle", cyc, FRAME);
      check($sformatf("vec%0d_joystick1", i), joystick1, vecs[i].e1);
      check($sformatf("vec%0d_joystick2", i), joystick2, vecs[i].e2);
      if (i < 5) begin
        cur_p1 = vecs[i+1].p1; cur_p2 = vecs[i+1].p2;
      end
    end

    // Random button patterns.
    for (int i = 0; i < 4; i++) begin
      cur_p1 = 12'($urandom);
      cur_p2 = 12'($urandom);
      wait_fd(cyc, ok);  // frame already underway used the previous words
      wait_fd(cyc, ok);
      check($sformatf("rand%0d_joystick1", i), joystick1, {4'h0, cur_p1});
      check($sformatf("rand%0d_joystick2", i), joystick2, {4'h0, cur_p2});
    end

    // Reset in the middle of HIGH for k=10 after a frame showed 0FFF.
    cur_p1 = 12'hFFF; cur_p2 = 12'h000;
    wait_fd(cyc, ok);
    wait_fd(cyc, ok);
    check("pre_abort_joystick1", joystick1, 16'h0FFF);
    cur_p1 = 12'h123; cur_p2 = 12'h456;
    r = 0; pc = JOY_CLK;
    for (int n = 0; n < 4000 && r < 11; n++) begin
      @(negedge clk_sys);
      if (JOY_CLK && !pc) r++;
      pc = JOY_CLK;
    end
    check("abort_reached_k10_high", r, 11);
    repeat (5) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check("abort_joy_clk", JOY_CLK, 0);
    check("abort_joy_load", JOY_LOAD, 1);
    check("abort_joystick1", joystick1, 0);
    check("abort_joystick2", joystick2, 0);
    check("abort_frame_done", frame_done, 0);
    repeat (2) @(negedge clk_sys);
    cur_p1 = 12'h0F0; cur_p2 = 12'h00F;
    reset = 1'b0;
    wait_fd(cyc, ok);
    check("restart_frame_done_cycle", cyc, FRAME);
    check("restart_joystick1", joystick1, 16'h00F0);
    check("restart_joystick2", joystick2, 16'h000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
